// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Shadows the destination registers of the instructions in EX, MEM and WB,
//   and from that shadow produces the load-use stall/bubble controls and the
//   registered EX-stage forwarding selects for a 5-stage MIPS pipeline.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      source register fields of the ID instruction
//   r1_used, r2_used  ID instruction actually reads rs / rt
//   id_dst            destination register of the ID instruction
//   id_reg_write      ID instruction writes the register file
//   id_mem_read       ID instruction is a load
//   flush             kill the ID instruction this cycle (wins over stall)
//   stall             hold PC and IF/ID (combinational)
//   bubble            load a NOP into ID/EX (combinational)
//   fwd_a, fwd_b      EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_count       saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             r1_used,
  input  logic             r2_used,
  input  logic [4:0]       id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] ZR = ZERO_REG[4:0];

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
  } slot_t;

  slot_t ex_s, mem_s, wb_s;
  logic  hz_a, hz_b;
  logic [1:0] nxt_a, nxt_b;

  function automatic logic writes(slot_t s, logic [4:0] r);
    return s.v & s.wr & (s.dst == r) & (r != ZR);
  endfunction

  // Nearer producer wins; a load still in EX never forwards (it stalls instead).
  function automatic logic [1:0] fwd_sel(logic used, logic [4:0] r,
                                         slot_t ex, slot_t mem);
    if (!used)                      return 2'b00;
    if (writes(ex, r) && !ex.ld)    return 2'b01;
    if (writes(mem, r))             return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    hz_a   = id_valid & r1_used & ex_s.ld & writes(ex_s, id_rs);
    hz_b   = id_valid & r2_used & ex_s.ld & writes(ex_s, id_rt);
    stall  = (hz_a | hz_b) & ~flush;
    bubble = stall | flush;
    nxt_a  = fwd_sel(r1_used, id_rs, ex_s, mem_s);
    nxt_b  = fwd_sel(r2_used, id_rt, ex_s, mem_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_s        <= '0;
      mem_s       <= '0;
      wb_s        <= '0;
      fwd_a       <= 2'b00;
      fwd_b       <= 2'b00;
      stall_count <= '0;
    end else begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      if (bubble) begin
        ex_s  <= '0;
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end else begin
        ex_s  <= '{v: id_valid, dst: id_dst, wr: id_reg_write, ld: id_mem_read};
        fwd_a <= nxt_a;
        fwd_b <= nxt_b;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // WB shadow is held for observability only: the regfile is write-first.
  logic unused_wb;
  assign unused_wb = ^wb_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic clk = 0;
  logic rst = 1;
  logic id_valid = 0, r1_used = 0, r2_used = 0, id_reg_write = 0, id_mem_read = 0, flush = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
  logic stall, bubble, s_stall, s_bubble;
  logic [1:0] fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic [31:0] stall_count;
  logic [1:0]  s_count;

  int checks = 0, errors = 0;
  bit go = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(32), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .r1_used(r1_used), .r2_used(r2_used), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .stall(stall), .bubble(bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count));

  hazard_scoreboard #(.CNT_W(2), .ZERO_REG(0)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .r1_used(r1_used), .r2_used(r2_used), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .stall(s_stall), .bubble(s_bubble),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_count(s_count));

  // ---------------- behavioural model ----------------
  typedef struct packed { logic v; logic [4:0] dst; logic wr; logic ld; } rec_t;
  rec_t inflight [$];          // [0] = instruction now in EX, [1] = MEM, [2] = WB
  logic [1:0] m_fa = 0, m_fb = 0;
  longint m_cnt = 0, m_cnt_sat = 0;

  function automatic bit produces(rec_t r, logic [4:0] reg_id);
    return r.v && r.wr && r.dst == reg_id && reg_id != 0;
  endfunction

  function automatic bit m_stall();
    bit need_a, need_b;
    need_a = id_valid && r1_used && inflight[0].ld && produces(inflight[0], id_rs);
    need_b = id_valid && r2_used && inflight[0].ld && produces(inflight[0], id_rt);
    return (need_a || need_b) && !flush;
  endfunction

  function automatic logic [1:0] m_fwd(bit used, logic [4:0] reg_id);
    if (!used) return 0;
    if (produces(inflight[0], reg_id) && !inflight[0].ld) return 1;
    if (produces(inflight[1], reg_id)) return 2;
    return 0;
  endfunction

  task automatic m_clear();
    inflight = {};
    repeat (3) inflight.push_back(rec_t'(0));
    m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt_sat = 0;
  endtask

  initial m_clear();

  always @(posedge clk or posedge rst) begin
    if (rst) m_clear();
    else begin
      bit st, kill;
      rec_t nr;
      st   = m_stall();
      kill = st || flush;
      if (st) begin
        m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
      if (kill) begin m_fa = 0; m_fb = 0; nr = 0; end
      else begin
        m_fa = m_fwd(r1_used, id_rs);
        m_fb = m_fwd(r2_used, id_rt);
        nr = '{v: id_valid, dst: id_dst, wr: id_reg_write, ld: id_mem_read};
      end
      inflight.push_front(nr);
      void'(inflight.pop_back());
    end
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) if (go) begin
    bit es;
    es = m_stall();
    chk("stall",      stall,       es);
    chk("bubble",     bubble,      es || flush);
    chk("fwd_a",      fwd_a,       m_fa);
    chk("fwd_b",      fwd_b,       m_fb);
    chk("count",      stall_count, m_cnt);
    chk("sat_count",  s_count,     m_cnt_sat);
    chk("sat_stall",  s_stall,     es);
  end

  // ---------------- stimulus ----------------
  task automatic drv(bit v, int rs, int rt, bit u1, bit u2, int dst, bit wr, bit ld, bit fl);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); r1_used = u1; r2_used = u2;
    id_dst = 5'(dst); id_reg_write = wr; id_mem_read = ld; flush = fl;
  endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic nop(); drv(0,0,0,0,0,0,0,0,0); endtask

  initial begin
    nop();
    #23 rst = 0;
    @(posedge clk); #1;
    go = 1;
    chk("rst_count", stall_count, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_stall", stall, 0);

    // load-use on rs: lw $8,0($9); add $10,$8,$11
    drv(1, 9,8, 1,0, 8,1,1, 0); tick();
    drv(1, 8,11, 1,1, 10,1,0, 0); #1;
    chk("lu_stall", stall, 1); chk("lu_bubble", bubble, 1);
    tick();
    chk("lu_stall_once", stall, 0); chk("lu_cnt", stall_count, 1);
    tick();
    chk("lu_fwd_a", fwd_a, 2); chk("lu_fwd_b", fwd_b, 0);

    // ALU-ALU: add $3,$1,$2; sub $4,$3,$3
    drv(1, 1,2, 1,1, 3,1,0, 0); tick();
    drv(1, 3,3, 1,1, 4,1,0, 0); #1;
    chk("alu_stall", stall, 0);
    tick();
    chk("alu_fwd_a", fwd_a, 1); chk("alu_fwd_b", fwd_b, 1);

    // double producer: add $5; add $5; or $6,$5,$0
    drv(1, 1,2, 1,1, 5,1,0, 0); tick();
    drv(1, 1,2, 1,1, 5,1,0, 0); tick();
    drv(1, 5,0, 1,1, 6,1,0, 0); tick();
    chk("dp_fwd_a", fwd_a, 1); chk("dp_fwd_b", fwd_b, 0);

    // unused operand vs. real use
    drv(1, 9,7, 1,0, 7,1,1, 0); tick();
    drv(1, 7,4, 0,1, 2,1,0, 0); #1;
    chk("unused_stall", stall, 0);
    tick();
    drv(1, 9,7, 1,0, 7,1,1, 0); tick();
    drv(1, 0,7, 0,1, 2,1,0, 0); #1;
    chk("sll_stall", stall, 1);
    tick(); nop(); tick();
    chk("cnt2", stall_count, 2);

    // flush during hazard
    drv(1, 9,8, 1,0, 8,1,1, 0); tick();
    drv(1, 8,11, 1,1, 10,1,0, 1); #1;
    chk("fl_stall", stall, 0); chk("fl_bubble", bubble, 1);
    tick();
    chk("fl_cnt", stall_count, 2);
    drv(1, 10,8, 1,1, 12,1,0, 0); #1;
    chk("fl_nostall", stall, 0);
    tick();
    chk("fl_fwd_a", fwd_a, 0); chk("fl_fwd_b", fwd_b, 2);

    // reset mid-stall
    drv(1, 9,8, 1,0, 8,1,1, 0); tick();
    drv(1, 8,11, 1,1, 10,1,0, 0); #1;
    chk("pre_rst_stall", stall, 1);
    rst = 1; #1;
    chk("mid_rst_cnt", stall_count, 0); chk("mid_rst_stall", stall, 0);
    chk("mid_rst_fwd", fwd_a, 0);
    tick(); rst = 0;

    // saturation: five load-use pairs
    repeat (5) begin
      drv(1, 9,8, 1,0, 8,1,1, 0); tick();
      drv(1, 8,11, 1,1, 10,1,0, 0); tick();
    end
    nop(); #1;
    chk("sat_hold", s_count, 3); chk("full_cnt", stall_count, 5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0,9) != 0, $urandom_range(0,3), $urandom_range(0,3),
          $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,3),
          $urandom_range(0,4) != 0, $urandom_range(0,4) < 2, $urandom_range(0,9) == 0);
      rst = ($urandom_range(0,99) == 0);
      tick();
    end
    rst = 0; nop(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
